// File: rtl/simeck_decryption.sv
// -----------------------------------------------------------------------------
// simeck_decryption
// Iterative Simeck-style 32-bit block decryptor with a 16-bit key.
// A start pulse (while idle) captures the ciphertext and key. The round-key
// schedule is then expanded into a local ROUNDS x 16 register array, one key
// per clock. The inverse Feistel rounds then run one per clock, last key first.
// The plaintext is presented with a one-cycle done pulse.
//
// Optional feature macro: SIMECK_KEYCACHE_EN
//   When defined, the last fully expanded key is remembered with a valid flag.
//   A start with a matching key skips expansion and goes straight to DECRYPT.
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   asynchronous, active-low reset
//   start  in   1   request, sampled only while idle
//   inp    in  32   ciphertext {L, R}
//   key    in  16   master key
//   out    out 32   plaintext {L, R}, held until the next done
//   busy   out  1   high while an operation is in progress
//   done   out  1   one-cycle pulse, out valid
// -----------------------------------------------------------------------------
module simeck_decryption #(
    parameter int ROUNDS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] inp,
    input  logic [15:0] key,
    output logic [31:0] out,
    output logic        busy,
    output logic        done
);

    localparam int            CW   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DECRYPT} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_lfsr;
    logic [15:0]   r_l;
    logic [15:0]   r_r;
    logic [15:0]   r_rk_cur;
    logic [15:0]   r_rk [ROUNDS];
    logic          w_hit;
    logic [15:0]   w_rk_next;
    logic [15:0]   w_r_next;

    function automatic logic [15:0] simeck_f(input logic [15:0] x);
        return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
    endfunction

    // Round constant 16'hFFFC ^ {15'b0, z}, with z taken from the LFSR LSB.
    assign w_rk_next = r_rk_cur ^ simeck_f(r_rk_cur) ^ {15'h7FFE, r_lfsr[0]};
    assign w_r_next  = r_l ^ simeck_f(r_r) ^ r_rk[r_cnt];

`ifdef SIMECK_KEYCACHE_EN
    logic [15:0] r_key;
    logic [15:0] r_cache_key;
    logic        r_cache_vld;
    assign w_hit = r_cache_vld && (key == r_cache_key);
`else
    assign w_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = w_hit ? S_DECRYPT : S_EXPAND;
            S_EXPAND:  if (r_cnt == LAST) w_next = S_DECRYPT;
            S_DECRYPT: if (r_cnt == '0) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (r_state != S_IDLE);
    end

    // Datapath, key schedule and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_lfsr   <= '0;
            r_l      <= '0;
            r_r      <= '0;
            r_rk_cur <= '0;
            out      <= '0;
            done     <= 1'b0;
            for (int i = 0; i < ROUNDS; i++) r_rk[i] <= '0;
`ifdef SIMECK_KEYCACHE_EN
            r_key       <= '0;
            r_cache_key <= '0;
            r_cache_vld <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_l      <= inp[31:16];
                        r_r      <= inp[15:0];
                        r_rk_cur <= key;
                        r_lfsr   <= 5'b11111;
                        r_cnt    <= w_hit ? LAST : '0;
`ifdef SIMECK_KEYCACHE_EN
                        r_key <= key;
                        // The array is about to be overwritten, so the cache
                        // must not be trusted until this expansion completes.
                        if (!w_hit) r_cache_vld <= 1'b0;
`endif
                    end
                end
                S_EXPAND: begin
                    // r_rk_cur always holds rk[cnt]; the next key is computed
                    // alongside so no array read is needed here.
                    r_rk[r_cnt] <= r_rk_cur;
                    r_rk_cur    <= w_rk_next;
                    r_lfsr      <= {r_lfsr[0] ^ r_lfsr[2], r_lfsr[4:1]};
                    if (r_cnt == LAST) begin
                        r_cnt <= LAST;
`ifdef SIMECK_KEYCACHE_EN
                        r_cache_key <= r_key;
                        r_cache_vld <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DECRYPT: begin
                    r_l <= r_r;
                    r_r <= w_r_next;
                    if (r_cnt == '0) begin
                        out  <= {r_r, w_r_next};
                        done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simeck_decryption.sv
// -----------------------------------------------------------------------------
// tb_simeck_decryption
// Scoreboard bench for simeck_decryption. Two instances are exercised: one with
// ROUNDS=32 and one with ROUNDS=1. Expected plaintexts come from a golden
// encryptor/decryptor in this file. They are queued at the accepting edge with
// the expected latency, then popped and checked on each done pulse.
// Latency expectations follow SIMECK_KEYCACHE_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_simeck_decryption;

    typedef struct {
        logic [31:0] pt;
        int          e0;
        int          lat;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start32 = 1'b0, start1 = 1'b0;
    logic [31:0] inp32 = '0, inp1 = '0;
    logic [15:0] key32 = '0, key1 = '0;
    logic [31:0] out32, out1;
    logic        busy32, busy1, done32, done1;

    int  cyc = 0;
    int  n_checks = 0;
    int  n_fail = 0;
    int  run32 = 0, run1 = 0;
    sb_t q32[$];
    sb_t q1[$];
    logic        cvld [2] = '{1'b0, 1'b0};
    logic [15:0] ckey [2] = '{16'h0, 16'h0};

    simeck_decryption #(.ROUNDS(32)) u_dut32 (
        .clk(clk), .rst(rst), .start(start32), .inp(inp32), .key(key32),
        .out(out32), .busy(busy32), .done(done32)
    );

    simeck_decryption #(.ROUNDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .inp(inp1), .key(key1),
        .out(out1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] f16(input logic [15:0] x);
        return (x & {x[10:0], x[15:11]}) ^ {x[14:0], x[15]};
    endfunction

    function automatic logic [31:0] encrypt(input logic [31:0] p, input logic [15:0] k, input int nr);
        logic [15:0] l, r, rk, t;
        logic [4:0]  s;
        l = p[31:16]; r = p[15:0]; rk = k; s = 5'h1F;
        for (int i = 0; i < nr; i++) begin
            t  = r ^ f16(l) ^ rk;
            r  = l;
            l  = t;
            rk = rk ^ f16(rk) ^ (16'hFFFC ^ {15'b0, s[0]});
            s  = {s[0] ^ s[2], s[4:1]};
        end
        return {l, r};
    endfunction

    function automatic logic [31:0] decrypt(input logic [31:0] c, input logic [15:0] k, input int nr);
        logic [15:0] rks [32];
        logic [15:0] l, r, t, rk;
        logic [4:0]  s;
        rk = k; s = 5'h1F;
        for (int i = 0; i < nr; i++) begin
            rks[i] = rk;
            rk = rk ^ f16(rk) ^ (16'hFFFC ^ {15'b0, s[0]});
            s  = {s[0] ^ s[2], s[4:1]};
        end
        l = c[31:16]; r = c[15:0];
        for (int i = nr - 1; i >= 0; i--) begin
            t = l ^ f16(r) ^ rks[i];
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        sb_t e;
        if (done32) begin
            if (q32.size() == 0) check("r32_spurious_done", 1, 0);
            else begin
                e = q32.pop_front();
                check("r32_out", out32, e.pt);
                check("r32_latency", cyc - e.e0, e.lat);
                check("r32_busy_len", run32, e.lat);
                check("r32_busy_at_done", busy32, 0);
            end
        end
        run32 <= busy32 ? run32 + 1 : 0;
    end

    always @(negedge clk) begin
        sb_t e;
        if (done1) begin
            if (q1.size() == 0) check("r1_spurious_done", 1, 0);
            else begin
                e = q1.pop_front();
                check("r1_out", out1, e.pt);
                check("r1_latency", cyc - e.e0, e.lat);
                check("r1_busy_len", run1, e.lat);
                check("r1_busy_at_done", busy1, 0);
            end
        end
        run1 <= busy1 ? run1 + 1 : 0;
    end

    // Called at a falling edge with the selected instance idle.
    task automatic issue(input int sel, input logic [31:0] c, input logic [15:0] k, input logic [31:0] p);
        int  r;
        int  lat;
        sb_t e;
        r   = (sel == 0) ? 32 : 1;
        lat = 2 * r;
`ifdef SIMECK_KEYCACHE_EN
        if (cvld[sel] && ckey[sel] == k) lat = r;
        cvld[sel] = 1'b1;
        ckey[sel] = k;
`endif
        if (sel == 0) begin start32 = 1'b1; inp32 = c; key32 = k; end
        else          begin start1  = 1'b1; inp1  = c; key1  = k; end
        @(posedge clk);
        #1;
        e.pt = p; e.e0 = cyc; e.lat = lat;
        if (sel == 0) begin q32.push_back(e); start32 = 1'b0; end
        else          begin q1.push_back(e);  start1  = 1'b0; end
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel == 0) ? busy32 : busy1) && n < 300);
        if ((sel == 0) ? busy32 : busy1) check("idle_wait_timeout", 1, 0);
    endtask

    logic [31:0] pts [22];
    logic [31:0] c;

    initial begin
        // Reset held: start toggling must have no effect.
        inp32 = 32'hFFFFFFFF; inp1 = 32'hFFFFFFFF;
        for (int i = 0; i < 4; i++) begin
            start32 = i[0]; start1 = ~i[0];
            @(negedge clk);
            check("rst_out32", out32, 0);
            check("rst_done32", done32, 0);
            check("rst_busy32", busy32, 0);
            check("rst_out1", out1, 0);
            check("rst_done1", done1, 0);
            check("rst_busy1", busy1, 0);
        end
        start32 = 1'b0; start1 = 1'b0;
        rst = 1'b1;

        // ROUNDS=1 known answers.
        wait_idle(1);
        issue(1, 32'h00000000, 16'hB5E5, 32'h0000B5E5);
        wait_idle(1);
        issue(1, 32'h00010000, 16'hB5E5, 32'h0000B5E4);
        wait_idle(1);

        // ROUNDS=32 round trip against the golden encryptor.
        pts[0] = 32'h00000000;
        for (int i = 1; i <= 20; i++) pts[i] = i;
        pts[21] = 32'hDEADBEEF;
        for (int i = 0; i < 22; i++) begin
            wait_idle(0);
            issue(0, encrypt(pts[i], 16'hB5E5, 32), 16'hB5E5, pts[i]);
        end
        wait_idle(0);

        // Key sensitivity: same ciphertext, neighbouring keys.
        c = 32'h3C5A9E17;
        issue(0, c, 16'hB5E5, decrypt(c, 16'hB5E5, 32));
        wait_idle(0);
        issue(0, c, 16'hB5E4, decrypt(c, 16'hB5E4, 32));
        wait_idle(0);

        // Busy protection: start held and inputs scrambled during the operation.
        issue(0, encrypt(32'hCAFEF00D, 16'h7A11, 32), 16'h7A11, 32'hCAFEF00D);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (!busy32) break;
            start32 = 1'b1;
            inp32   = $urandom;
            key32   = 16'($urandom);
        end
        start32 = 1'b0;
        // Accepted on the edge right after done.
        issue(0, encrypt(32'h12345678, 16'h0BAD, 32), 16'h0BAD, 32'h12345678);
        wait_idle(0);

        // Back-to-back with the same key, then a new key.
        issue(0, encrypt(32'hA5A50F0F, 16'hB5E5, 32), 16'hB5E5, 32'hA5A50F0F);
        wait_idle(0);
        issue(0, encrypt(32'h0F0FA5A5, 16'hB5E5, 32), 16'hB5E5, 32'h0F0FA5A5);
        wait_idle(0);
        issue(0, encrypt(32'h11223344, 16'h1234, 32), 16'h1234, 32'h11223344);
        wait_idle(0);

        // Reset in the middle of DECRYPT: immediate idle, no done.
        issue(0, encrypt(32'h55AA55AA, 16'h0F0F, 32), 16'h0F0F, 32'h55AA55AA);
        repeat (40) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy32, 0);
        check("abort_done", done32, 0);
        check("abort_out", out32, 0);
        q32.delete();
        cvld[0] = 1'b0; cvld[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (70) @(negedge clk);
        check("abort_no_done_queue", q32.size(), 0);

        // Recovery after the abort.
        issue(0, encrypt(32'h55AA55AA, 16'h0F0F, 32), 16'h0F0F, 32'h55AA55AA);
        wait_idle(0);
        issue(1, 32'h00010000, 16'hB5E5, 32'h0000B5E4);
        wait_idle(1);

        repeat (3) @(negedge clk);
        check("drain_q32", q32.size(), 0);
        check("drain_q1", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d checks, expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
